tuning_controller: RTL and testbench

//  Front-panel tuning controller for the FM receiver. Samples the rotary encoder (A/B) and the

---
 rtl/tuning_pkg.sv | 23 ++
 rtl/tuning_controller_if.sv | 32 +++
 rtl/tuning_controller_debouncer.sv | 38 +++
 rtl/tuning_controller_sync.sv | 28 ++
 rtl/tuning_controller.sv | 173 +++++++++++++++++
 tb/tb_tuning_controller.sv | 165 ++++++++++++++++
 6 files changed

// File: rtl/tuning_pkg.sv
// rtl/tuning_pkg.sv - shared tuning types, band edges and step sizes
//
// Purpose : types and constants shared by the tuning controller, display and NCO blocks.
// Contents: TUNING_FREQ_W, freq_t, tuning_state_e, band-edge and step constants.
package tuning_pkg;

  localparam int TUNING_FREQ_W = 32;

  typedef logic [TUNING_FREQ_W-1:0] freq_t;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    IDLE    = 2'd1,
    PRESENT = 2'd2
  } tuning_state_e;

  localparam freq_t BAND_MIN    = freq_t'(87_500_000);
  localparam freq_t BAND_MAX    = freq_t'(108_000_000);
  localparam freq_t BAND_RESET  = freq_t'(87_500_000);
  localparam freq_t STEP_FINE   = freq_t'(100_000);
  localparam freq_t STEP_COARSE = freq_t'(1_000_000);

endpackage

// File: rtl/tuning_controller_if.sv
// rtl/tuning_controller_if.sv - tuning word handshake towards the NCO/tuner
//
// Purpose : groups the frequency hand-off and the step-size display signal.
// Signals : freq        tuning word [Hz]
//           freq_valid  freq is valid, held until accepted
//           freq_ready  tuner accepts freq when freq_valid && freq_ready
//           step_coarse current step size (1 = coarse), for display
// Modports: master = tuning controller, slave = tuner/display side.
interface tuning_controller_if #(
  parameter int FREQ_W = tuning_pkg::TUNING_FREQ_W
);

  logic [FREQ_W-1:0] freq;
  logic              freq_valid;
  logic              freq_ready;
  logic              step_coarse;

  modport master (
    output freq,
    output freq_valid,
    output step_coarse,
    input  freq_ready
  );

  modport slave (
    input  freq,
    input  freq_valid,
    input  step_coarse,
    output freq_ready
  );

endinterface

// File: rtl/tuning_controller_debouncer.sv
// rtl/tuning_controller_debouncer.sv - tick-based level debouncer
//
// Purpose : accepts a new level only after DEBOUNCE consecutive enabled samples
//           disagree with the current level; any agreeing sample restarts the count.
// Ports   : clk, reset (async, active-high), en (sample tick), in (synchronized),
//           out (debounced level)
module debouncer #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic in,
  output logic out
);

  localparam int CW = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      out <= 1'b0;
    end else if (en) begin
      if (in == out) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE - 1)) begin
        // this tick is the DEBOUNCE-th disagreeing sample
        out <= in;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tuning_controller_sync.sv
// rtl/tuning_controller_sync.sv - enabled multi-stage input synchronizer
//
// Purpose : brings an asynchronous panel input into the clk domain; the chain
//           only advances when en is high, so latency is STAGES enable pulses.
// Ports   : clk, reset (async, active-high), en, in (async), out (synchronized)
module synchronizer #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic in,
  output logic out
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else if (en) begin
      chain <= {chain[STAGES-2:0], in};
    end
  end

  assign out = chain[STAGES-1];

endmodule

// File: rtl/tuning_controller.sv
// rtl/tuning_controller.sv - front-panel rotary encoder tuning controller
//
// Purpose : samples encoder A/B and the step button on a divided tick, debounces
//           them, turns detents into wrapped up/down frequency steps and presents
//           each new frequency to the tuner over a valid/ready handshake.
// Ports   : clk            clock
//           reset          asynchronous, active-high reset
//           enc_a, enc_b   encoder phases, asynchronous
//           btn            step-size button, asynchronous, active-high
//           tune           tuning_controller_if.master (freq, freq_valid,
//                          freq_ready, step_coarse)
module tuning_controller
  import tuning_pkg::*;
#(
  parameter int                CLK_DIV       = 1000,
  parameter int                DEBOUNCE      = 4,
  parameter int                FREQ_W        = TUNING_FREQ_W,
  parameter logic [FREQ_W-1:0] F_MIN         = FREQ_W'(BAND_MIN),
  parameter logic [FREQ_W-1:0] F_MAX         = FREQ_W'(BAND_MAX),
  parameter logic [FREQ_W-1:0] F_RESET       = FREQ_W'(BAND_RESET),
  parameter logic [FREQ_W-1:0] F_STEP_FINE   = FREQ_W'(STEP_FINE),
  parameter logic [FREQ_W-1:0] F_STEP_COARSE = FREQ_W'(STEP_COARSE)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enc_a,
  input  logic                enc_b,
  input  logic                btn,
  tuning_controller_if.master tune
);

  localparam int CNT_W = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);

  // ---------------------------------------------------------------- sample tick
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;

  assign tick = (tick_cnt == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // ------------------------------------------------------- synchronize/debounce
  logic a_sync, b_sync, btn_sync;
  logic a_db, b_db, btn_db;

  synchronizer #(.STAGES(3)) u_sync_a   (.clk(clk), .reset(reset), .en(tick), .in(enc_a), .out(a_sync));
  synchronizer #(.STAGES(3)) u_sync_b   (.clk(clk), .reset(reset), .en(tick), .in(enc_b), .out(b_sync));
  synchronizer #(.STAGES(3)) u_sync_btn (.clk(clk), .reset(reset), .en(tick), .in(btn),   .out(btn_sync));

  debouncer #(.DEBOUNCE(DEBOUNCE)) u_db_a   (.clk(clk), .reset(reset), .en(tick), .in(a_sync),   .out(a_db));
  debouncer #(.DEBOUNCE(DEBOUNCE)) u_db_b   (.clk(clk), .reset(reset), .en(tick), .in(b_sync),   .out(b_db));
  debouncer #(.DEBOUNCE(DEBOUNCE)) u_db_btn (.clk(clk), .reset(reset), .en(tick), .in(btn_sync), .out(btn_db));

  // ------------------------------------------------------------------- decoder
  logic a_prev, btn_prev;
  logic a_rise, btn_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_prev   <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      a_prev   <= a_db;
      btn_prev <= btn_db;
    end
  end

  // only the A rising edge counts, giving one step per detent
  assign a_rise   = a_db & ~a_prev;
  assign btn_rise = btn_db & ~btn_prev;

  // ------------------------------------------------------- target + wrap logic
  logic [FREQ_W-1:0] target;
  logic              step_coarse_q;
  logic [FREQ_W:0]   step_x;
  logic [FREQ_W:0]   target_x;
  logic [FREQ_W:0]   up_x;
  logic [FREQ_W:0]   min_plus_step_x;
  logic [FREQ_W-1:0] target_up;
  logic [FREQ_W-1:0] target_dn;

  // one extra bit so neither sum can overflow before the band compare
  assign step_x          = {1'b0, (step_coarse_q ? F_STEP_COARSE : F_STEP_FINE)};
  assign target_x        = {1'b0, target};
  assign up_x            = target_x + step_x;
  assign min_plus_step_x = {1'b0, F_MIN} + step_x;

  assign target_up = (up_x > {1'b0, F_MAX}) ? F_MIN : up_x[FREQ_W-1:0];
  assign target_dn = (target_x < min_plus_step_x) ? F_MAX : (target - step_x[FREQ_W-1:0]);

  // step_coarse is read before it toggles, so a step on the toggle cycle
  // still uses the old step size
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target        <= F_RESET;
      step_coarse_q <= 1'b0;
    end else begin
      if (a_rise) begin
        target <= b_db ? target_dn : target_up;
      end
      if (btn_rise) begin
        step_coarse_q <= ~step_coarse_q;
      end
    end
  end

  assign tune.step_coarse = step_coarse_q;

  // ---------------------------------------------------------------- output FSM
  tuning_state_e     state, state_n;
  logic [FREQ_W-1:0] freq_q, freq_n;
  logic              valid_q, valid_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= INIT;
      freq_q  <= F_RESET;
      valid_q <= 1'b0;
    end else begin
      state   <= state_n;
      freq_q  <= freq_n;
      valid_q <= valid_n;
    end
  end

  // freq only changes on a handshake or from IDLE, so it is stable while stalled;
  // steps during a stall only move target and are coalesced into the next value
  always_comb begin
    state_n = state;
    freq_n  = freq_q;
    valid_n = valid_q;
    case (state)
      INIT: begin
        state_n = PRESENT;
        freq_n  = target;
        valid_n = 1'b1;
      end
      IDLE: begin
        if (target != freq_q) begin
          state_n = PRESENT;
          freq_n  = target;
          valid_n = 1'b1;
        end
      end
      PRESENT: begin
        if (tune.freq_ready) begin
          if (target != freq_q) begin
            freq_n = target;
          end else begin
            valid_n = 1'b0;
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = INIT;
        valid_n = 1'b0;
      end
    endcase
  end

  assign tune.freq       = freq_q;
  assign tune.freq_valid = valid_q;

endmodule

// File: tb/tb_tuning_controller.sv
// tb/tb_tuning_controller.sv - directed self-checking bench for tuning_controller
module tb_tuning_controller;

  localparam int CLK_DIV  = 4;
  localparam int DEBOUNCE = 2;
  localparam int LAT      = 28;   // >= (3+DEBOUNCE+1)*CLK_DIV+2 plus one clk to freq

  localparam logic [31:0] F_MIN = 32'd87_500_000;
  localparam logic [31:0] F_MAX = 32'd108_000_000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enc_a = 1'b0;
  logic enc_b = 1'b0;
  logic btn = 1'b0;

  int total = 0;
  int bad = 0;

  logic [31:0] xfers[$];
  int          n0;

  always #5 clk = ~clk;

  tuning_controller_if #(.FREQ_W(32)) tif ();

  tuning_controller #(
    .CLK_DIV (CLK_DIV),
    .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .enc_a(enc_a),
    .enc_b(enc_b),
    .btn  (btn),
    .tune (tif.master)
  );

  // transfer log: every accepted freq value
  always @(posedge clk) begin
    if (!reset && tif.freq_valid && tif.freq_ready) begin
      xfers.push_back(tif.freq);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic detent_cw();
    enc_a = 1'b1; clks(LAT);
    enc_a = 1'b0; clks(LAT);
  endtask

  task automatic detent_ccw();
    enc_b = 1'b1; clks(LAT);
    enc_a = 1'b1; clks(LAT);
    enc_a = 1'b0; clks(LAT);
    enc_b = 1'b0; clks(LAT);
  endtask

  task automatic press_btn();
    btn = 1'b1; clks(LAT);
    btn = 1'b0; clks(LAT);
  endtask

  initial begin
    tif.freq_ready = 1'b1;

    // 1: reset state, single valid pulse after release
    clks(3);
    chk("rst_freq", tif.freq, F_MIN);
    chk("rst_valid", tif.freq_valid, 0);
    chk("rst_coarse", tif.step_coarse, 0);
    reset = 1'b0;
    clks(1);
    chk("init_valid", tif.freq_valid, 1);
    chk("init_freq", tif.freq, F_MIN);
    clks(1);
    chk("init_idle", tif.freq_valid, 0);
    chk("init_xfers", xfers.size(), 1);
    chk("init_xfer0", xfers[0], F_MIN);

    // 2: CW within bound, CCW back, CCW wraps to top
    enc_a = 1'b1; clks(LAT);
    chk("cw_bound", tif.freq, 32'd87_600_000);
    enc_a = 1'b0; clks(LAT);
    chk("cw_idle", tif.freq_valid, 0);
    detent_ccw();
    chk("ccw1", tif.freq, F_MIN);
    detent_ccw();
    chk("ccw_wrap", tif.freq, F_MAX);

    // 3: down to 107.5M, coarse step wraps past F_MAX to F_MIN
    for (int i = 0; i < 5; i++) detent_ccw();
    chk("ccw_x5", tif.freq, 32'd107_500_000);
    press_btn();
    chk("coarse_on", tif.step_coarse, 1);
    detent_cw();
    chk("coarse_wrap", tif.freq, F_MIN);
    press_btn();
    chk("coarse_off", tif.step_coarse, 0);

    // 4: stall coalesces five steps into one back-to-back transfer
    tif.freq_ready = 1'b0;
    detent_cw();
    chk("stall_freq1", tif.freq, 32'd87_600_000);
    chk("stall_valid1", tif.freq_valid, 1);
    for (int i = 0; i < 4; i++) detent_cw();
    chk("stall_freq5", tif.freq, 32'd87_600_000);
    chk("stall_valid5", tif.freq_valid, 1);
    n0 = xfers.size();
    tif.freq_ready = 1'b1;
    clks(5);
    chk("coal_count", xfers.size() - n0, 2);
    if (xfers.size() >= n0 + 2) begin
      chk("coal_first", xfers[n0], 32'd87_600_000);
      chk("coal_second", xfers[n0+1], 32'd88_000_000);
    end
    chk("coal_idle", tif.freq_valid, 0);

    // 5: glitches shorter than the debounce window never step
    n0 = xfers.size();
    enc_a = 1'b1; clks(CLK_DIV);
    enc_a = 1'b0; clks(LAT);
    chk("glitch_tick_freq", tif.freq, 32'd88_000_000);
    enc_a = 1'b1; clks(1);
    enc_a = 1'b0; clks(LAT);
    chk("glitch_clk_freq", tif.freq, 32'd88_000_000);
    chk("glitch_xfers", xfers.size() - n0, 0);

    // 6: reset mid-handshake drops valid immediately
    tif.freq_ready = 1'b0;
    detent_cw();
    chk("pre_rst_valid", tif.freq_valid, 1);
    chk("pre_rst_freq", tif.freq, 32'd88_100_000);
    n0 = xfers.size();
    #1 reset = 1'b1;
    #1;
    chk("async_valid", tif.freq_valid, 0);
    chk("async_freq", tif.freq, F_MIN);
    clks(2);
    reset = 1'b0;
    clks(1);
    chk("rel_valid", tif.freq_valid, 1);
    chk("rel_freq", tif.freq, F_MIN);
    tif.freq_ready = 1'b1;
    clks(2);
    chk("rel_idle", tif.freq_valid, 0);
    chk("rel_xfers", xfers.size() - n0, 1);
    if (xfers.size() > n0) chk("rel_xfer_val", xfers[n0], F_MIN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
